// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: accepts target pulse widths over valid/ready and slews angle toward them by at most STEP per frame.
// Optional feature macro SERVO_SLEW_CLAMP_EN clamps accepted commands into [MIN_WIDTH, MAX_WIDTH].
module servo_slew_ctrl #(
  parameter int unsigned FRAME_CYCLES = 2_000_000,
  parameter int unsigned STEP         = 500,
  parameter int unsigned MIN_WIDTH    = 50_000,
  parameter int unsigned MAX_WIDTH    = 250_000,
  parameter int unsigned INIT_WIDTH   = 150_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_angle,
  input  logic        abort,
  output logic [23:0] angle,
  output logic        en,
  output logic        frame_tick,
  output logic        busy,
  output logic        done,
  output logic        clamped
);

  localparam int unsigned CNT_W = (FRAME_CYCLES > 32'd1) ? $clog2(FRAME_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 32'd1);
  localparam logic [23:0] MIN_W   = 24'(MIN_WIDTH);
  localparam logic [23:0] MAX_W   = 24'(MAX_WIDTH);
  localparam logic [23:0] STEP_W  = 24'(STEP);
  localparam logic [24:0] STEP_25 = 25'(STEP);

  function automatic logic [23:0] clamp_width(input logic [23:0] w);
    logic [23:0] r;
    if (w < MIN_W) begin
      r = MIN_W;
    end else if (w > MAX_W) begin
      r = MAX_W;
    end else begin
      r = w;
    end
    return r;
  endfunction

  // A misconfigured INIT_WIDTH must never park the servo outside its mechanical range.
  localparam logic [23:0] INIT_W = clamp_width(24'(INIT_WIDTH));

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [23:0]       angle_q, angle_d;
  logic [23:0]       target_q, target_d;
  logic              ready_q, ready_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              clamped_q, clamped_d;

  logic [23:0]        cmd_load_s;
  logic               cmd_clip_s;
  logic               accept_s;
  logic signed [24:0] diff_s;
  logic [24:0]        mag_s;

`ifdef SERVO_SLEW_CLAMP_EN
  // Command conditioning: out-of-range targets are pulled to the nearest legal width.
  always_comb begin
    cmd_load_s = clamp_width(cmd_angle);
    cmd_clip_s = (cmd_angle < MIN_W) || (cmd_angle > MAX_W);
  end
`else
  // Command conditioning: targets pass through untouched.
  always_comb begin
    cmd_load_s = cmd_angle;
    cmd_clip_s = 1'b0;
  end
`endif

  // Next-state, frame counter and slew arithmetic.
  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d    = (cnt_q == CNT_LAST);
    en_d      = enable;
    state_d   = state_q;
    angle_d   = angle_q;
    target_d  = target_q;
    done_d    = 1'b0;
    clamped_d = 1'b0;
    accept_s  = cmd_valid & ready_q;
    diff_s    = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
    mag_s     = diff_s[24] ? $unsigned(-diff_s) : $unsigned(diff_s);

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          target_d  = cmd_load_s;
          clamped_d = cmd_clip_s;
          if (cmd_load_s != angle_q) begin
            state_d = SLEW;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SLEW: begin
        // abort beats a coincident tick so the servo freezes exactly where it is.
        if (abort) begin
          target_d = angle_q;
          state_d  = IDLE;
        end else if (tick_q && enable) begin
          if (mag_s <= STEP_25) begin
            angle_d = target_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (diff_s[24]) begin
            angle_d = angle_q - STEP_W;
          end else begin
            angle_d = angle_q + STEP_W;
          end
        end else begin
          state_d = SLEW;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      angle_q   <= INIT_W;
      target_q  <= INIT_W;
      ready_q   <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      angle_q   <= angle_d;
      target_q  <= target_d;
      ready_q   <= ready_d;
      en_q      <= en_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign angle      = angle_q;
  assign en         = en_q;
  assign frame_tick = tick_q;
  assign busy       = (state_q == SLEW);
  assign done       = done_q;
  assign clamped    = clamped_q;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Self-checking bench for servo_slew_ctrl: command table with a trajectory scoreboard,
// plus hand-written reset-mid-slew, abort-on-tick and enable-gating sequences.
module tb_servo_slew_ctrl;

  localparam int FC    = 100;
  localparam int STEP  = 500;
  localparam int INITW = 150000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_angle = 24'd0;
  logic        abort = 1'b0;
  logic        cmd_ready, en, frame_tick, busy, done, clamped;
  logic [23:0] angle;

  servo_slew_ctrl #(
    .FRAME_CYCLES(FC),
    .STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_angle(cmd_angle), .abort(abort), .angle(angle),
    .en(en), .frame_tick(frame_tick), .busy(busy), .done(done), .clamped(clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cmd;
    logic        ab;
    logic [23:0] tgt;
    logic        clp;
  } vec_t;

  vec_t        vecs[5];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edges = 0;
  logic        mon_on = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] model_angle = 24'(INITW);
  logic [23:0] last_angle = 24'(INITW);

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk24(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm, input int waited, input int limit);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout, waited %0d cycles, limit %0d", nm, waited, limit);
  endtask

  // Posedges since reset release; frame ticks fall on every FC-th edge.
  always @(posedge clk) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (mon_on) chkb("frame_tick", frame_tick, (edges % FC == 0) && (edges != 0));
  end

  // Issue one command away from any tick, check cycle N+1 and queue the expected trajectory.
  task automatic send_cmd(input logic [23:0] val, input logic ab, input logic [23:0] tgt, input logic clp);
    int w;
    int a;
    int t;
    w = 0;
    while (!(cmd_ready === 1'b1 && edges % FC == 20)) begin
      @(negedge clk);
      w++;
      if (w > 3 * FC) begin
        timeout("cmd_wait", w, 3 * FC);
        return;
      end
    end
    cmd_valid = 1'b1;
    cmd_angle = val;
    abort     = ab;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chkb("busy_n1", busy, tgt != model_angle);
    chkb("ready_n1", cmd_ready, tgt == model_angle);
    chkb("clamped_n1", clamped, clp);
    chkb("done_n1", done, tgt == model_angle);
    a = int'(model_angle);
    t = int'(tgt);
    while (a != t) begin
      if (t > a) a = (t - a <= STEP) ? t : a + STEP;
      else       a = (a - t <= STEP) ? t : a - STEP;
      exp_q.push_back(24'(a));
    end
    @(negedge clk);
    chkb("clamped_width", clamped, 1'b0);
    chkb("done_width", done, 1'b0);
  endtask

  // Consume up to n_max angle changes from the scoreboard, checking handshake outputs every cycle.
  task automatic run_moves(input int n_max, input int budget);
    int moved;
    int cyc;
    logic [23:0] e;
    moved = 0;
    cyc = 0;
    while (moved < n_max && exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (angle !== last_angle) begin
        e = exp_q.pop_front();
        moved++;
        chk24("angle_step", angle, e);
        chk32("step_phase", edges % FC, 1);
        chkb("done_on_arrival", done, exp_q.size() == 0);
        model_angle = e;
        last_angle  = angle;
      end else begin
        chkb("done_idle", done, 1'b0);
      end
      chkb("busy_slew", busy, exp_q.size() != 0);
      chkb("ready_slew", cmd_ready, exp_q.size() == 0);
      chkb("clamped_slew", clamped, 1'b0);
      if (cyc > budget) begin
        timeout("run_moves", cyc, budget);
        return;
      end
    end
  endtask

  initial begin
    int w;
    vecs[0] = '{24'd151200, 1'b0, 24'd151200, 1'b0};
    vecs[1] = '{24'd150000, 1'b1, 24'd150000, 1'b0};
    vecs[2] = '{24'd149000, 1'b0, 24'd149000, 1'b0};
    vecs[3] = '{24'd149000, 1'b0, 24'd149000, 1'b0};
`ifdef SERVO_SLEW_CLAMP_EN
    vecs[4] = '{24'd300000, 1'b0, 24'd250000, 1'b1};
`else
    vecs[4] = '{24'd300000, 1'b0, 24'd300000, 1'b0};
`endif

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk24("rst_angle", angle, 24'(INITW));
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_ready", cmd_ready, 1'b0);
      chkb("rst_outs", en | frame_tick | done | clamped, 1'b0);
    end
    rst_n  = 1'b1;
    enable = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chkb("ready_after_rst", cmd_ready, 1'b1);
    chkb("en_after_rst", en, 1'b1);
    chk24("angle_after_rst", angle, 24'(INITW));

    for (int i = 0; i < 5; i++) begin
      send_cmd(vecs[i].cmd, vecs[i].ab, vecs[i].tgt, vecs[i].clp);
      run_moves(1000, exp_q.size() * FC + 2 * FC);
      chk24("final_angle", angle, vecs[i].tgt);
    end

    // Reset in the middle of a slew snaps angle straight back.
    send_cmd(24'd240000, 1'b0, 24'd240000, 1'b0);
    run_moves(1, 2 * FC);
    rst_n = 1'b0;
    @(negedge clk);
    chk24("midrst_angle", angle, 24'(INITW));
    chkb("midrst_busy", busy, 1'b0);
    chkb("midrst_ready", cmd_ready, 1'b0);
    chkb("midrst_en", en, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    model_angle = 24'(INITW);
    last_angle  = 24'(INITW);
    @(negedge clk);
    chkb("midrst_ready_rel", cmd_ready, 1'b1);
    chk24("midrst_angle_rel", angle, 24'(INITW));

    // Abort coincident with the first tick: no step, IDLE next cycle, no done.
    send_cmd(24'd160000, 1'b0, 24'd160000, 1'b0);
    w = 0;
    while (!(edges % FC == 0 && edges != 0)) begin
      @(negedge clk);
      w++;
      if (w > 2 * FC) begin
        timeout("abort_tick_wait", w, 2 * FC);
        break;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk24("abort_angle", angle, 24'(INITW));
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_ready", cmd_ready, 1'b1);
    chkb("abort_done", done, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 2 * FC; i++) begin
      @(negedge clk);
      chk24("abort_hold", angle, 24'(INITW));
      chkb("abort_no_done", done, 1'b0);
      chkb("abort_idle", busy, 1'b0);
    end

    // Enable gating: hold angle for 3 frames, resume on the first tick after re-enable.
    send_cmd(24'd153000, 1'b0, 24'd153000, 1'b0);
    run_moves(1, 2 * FC);
    enable = 1'b0;
    @(negedge clk);
    chkb("en_drop", en, 1'b0);
    for (int i = 0; i < 3 * FC; i++) begin
      @(negedge clk);
      chk24("gated_hold", angle, model_angle);
      chkb("gated_busy", busy, 1'b1);
      chkb("gated_ready", cmd_ready, 1'b0);
    end
    enable = 1'b1;
    @(negedge clk);
    chkb("en_rise", en, 1'b1);
    run_moves(1000, exp_q.size() * FC + FC / 2);
    chk24("gated_final", angle, 24'd153000);
    chk32("gated_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
